// File: rtl/win_banner_object.sv
// rtl/win_banner_object.sv - slide-in/hold/slide-out position and per-pixel geometry for the win banner
// Optional blink in HOLD: define WIN_BANNER_BLINK_EN.
module win_banner_object #(
    parameter int OBJECT_WIDTH  = 140,
    parameter int OBJECT_HEIGHT = 24,
    parameter int TOP_LEFT_X    = 250,
    parameter int TARGET_Y      = 200,
    parameter int SLIDE_SPEED   = 4,
    parameter int HOLD_FRAMES   = 180
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        show_req,
    input  logic        hide_req,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        bannerActive,
    output logic        bannerBusy
);

    typedef enum logic [1:0] {IDLE, SLIDE_IN, HOLD, SLIDE_OUT} state_t;

    localparam logic signed [11:0] X0    = 12'(TOP_LEFT_X);
    localparam logic signed [11:0] X_END = 12'(TOP_LEFT_X + OBJECT_WIDTH);
    localparam logic signed [11:0] H     = 12'(OBJECT_HEIGHT);
    localparam logic signed [11:0] TY    = 12'(TARGET_Y);
    localparam logic signed [11:0] SPD   = 12'(SLIDE_SPEED);
    localparam logic signed [11:0] Y_OFF = 12'(-OBJECT_HEIGHT);
    localparam logic [15:0]        HOLD_LAST = 16'(HOLD_FRAMES - 1);
    localparam logic [10:0]        X0_U  = 11'(TOP_LEFT_X);

    state_t             state;
    logic signed [11:0] top_y;
    logic [15:0]        hold_cnt;
    logic signed [11:0] px, py, y_end, next_in, next_out;
    logic [10:0]        dx, dy;
    logic               show_eff, visible, inside_now;

`ifdef WIN_BANNER_BLINK_EN
    logic       blink_phase;
    logic [3:0] blink_cnt;
    assign visible = !((state == HOLD) && blink_phase);
`else
    assign visible = 1'b1;
`endif

    // hide always dominates, so a simultaneous show is dropped entirely
    assign show_eff = show_req && !hide_req;
    assign px       = $signed({1'b0, pixelX});
    assign py       = $signed({1'b0, pixelY});
    assign y_end    = top_y + H;
    assign next_in  = top_y + SPD;
    assign next_out = top_y - SPD;
    assign dx       = pixelX - X0_U;
    assign dy       = pixelY - top_y[10:0];

    always_comb begin
        inside_now = (state != IDLE) && (px >= X0) && (px < X_END) &&
                     (py >= top_y) && (py < y_end) && visible;
    end

    assign bannerActive = (state == HOLD);
    assign bannerBusy   = (state != IDLE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= inside_now;
            offsetX         <= inside_now ? dx : 11'd0;
            offsetY         <= inside_now ? dy : 11'd0;
        end
    end

    // a request taken in a startOfFrame cycle pre-empts that frame's position step
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            top_y    <= Y_OFF;
            hold_cnt <= '0;
`ifdef WIN_BANNER_BLINK_EN
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (show_eff) begin
                        state <= SLIDE_IN;
                        top_y <= Y_OFF;
                    end
                end
                SLIDE_IN: begin
                    if (hide_req) begin
                        state <= SLIDE_OUT;
                    end else if (startOfFrame) begin
                        if (next_in >= TY) begin
                            top_y    <= TY;
                            state    <= HOLD;
                            hold_cnt <= '0;
`ifdef WIN_BANNER_BLINK_EN
                            blink_phase <= 1'b0;
                            blink_cnt   <= '0;
`endif
                        end else begin
                            top_y <= next_in;
                        end
                    end
                end
                HOLD: begin
                    if (hide_req) begin
                        state <= SLIDE_OUT;
                    end else if (show_eff) begin
                        hold_cnt <= '0;
                    end else if (startOfFrame) begin
                        if ((HOLD_FRAMES != 0) && (hold_cnt == HOLD_LAST)) begin
                            state <= SLIDE_OUT;
                        end else begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
`ifdef WIN_BANNER_BLINK_EN
                        blink_cnt <= blink_cnt + 4'd1;
                        if (blink_cnt == 4'd15) begin
                            blink_phase <= ~blink_phase;
                        end
`endif
                    end
                end
                SLIDE_OUT: begin
                    if (show_eff) begin
                        state <= SLIDE_IN;
                    end else if (startOfFrame) begin
                        if (next_out <= Y_OFF) begin
                            top_y <= Y_OFF;
                            state <= IDLE;
                        end else begin
                            top_y <= next_out;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
